cmp_unit_seq: RTL and testbench
===============================

# cmp_unit_seq

Sequential, parametrised compare unit for the CPU's branch and set-on-compare path. It is the successor to the original single-cycle 32-bit comparator. It adds parameterised operand width, signed/unsigned mode, and a full six-relation operation set that stays backward-compatible with the 2-bit encoding. Operands are compared MSB-first in CHUNK-bit slices, one slice per cycle, with early termination at the first differing slice. The unit uses a valid/ready handshake on both the operand and the result sides.

## Interface
Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; NSLICE = WIDTH/CHUNK, and NSLICE ≥ 1.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand request valid.
- in_ready  output  1  unit can accept a request; high only in IDLE.
- op1, op2  input  WIDTH  operands.
- operation  input  3  bits [1:0] select the relation (11 eq, 01 gt, 10 lt); bit 2 inverts the result (111 ne, 101 le, 110 ge); x00 is illegal.
- is_signed  input  1  1 = two's-complement compare; 0 = unsigned.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- result  output  1  compare outcome.
- illegal  output  1  the captured operation was x00.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture op1, op2, operation and is_signed, and set the slice index to NSLICE-1.
  - A legal op goes to SCAN.
  - An illegal op goes to DONE with result=0 and illegal=1.
- SCAN: each cycle, compare slice [idx*CHUNK +: CHUNK] of the two captured operands.
  - If the slices differ, decide lt/gt from that slice and go to DONE.
  - On the top slice with is_signed=1, the compare is signed (the slice MSB is the sign bit). All other slices are compared unsigned.
  - If the slices are equal and idx==0, the operands are equal; go to DONE.
  - Otherwise decrement idx and stay in SCAN.
- Result computation from the lt/gt/eq flags:
  - base = (op[1:0]==11) ? eq : (op[1:0]==01) ? gt : lt.
  - result = base XOR op[2].
  - is_signed has no effect on eq/ne.
- DONE:
  - out_valid=1; result and illegal are held stable.
  - On out_ready, go to IDLE. out_valid drops in the next cycle.
- in_ready is 0 in SCAN and DONE. in_valid is ignored there and no request is captured.
- Captured operands are immune to input changes after the accept edge.
- Reset (rst_n low at a rising edge):
  - state becomes IDLE; result=0, illegal=0, out_valid=0; in_ready=1 from the next cycle.
  - Reset during SCAN or DONE aborts the operation. No out_valid is produced for it.

## Timing
- Registered outputs: result, illegal, out_valid. in_ready is decoded from state.
- Latency is counted from the accept edge (edge 0) to the first edge at which out_valid is sampled high.
  - Legal op: k+1 cycles, where k is the number of slices examined (1..NSLICE).
  - Illegal op: 1 cycle.
- Worst case (all slices examined or operands equal) is NSLICE+1. With the defaults this is 5.
- Minimum issue interval: k+2 cycles (the extra cycle is the return to IDLE). There is no overlap between operations.
- With out_ready tied high, DONE lasts exactly 1 cycle.
- Boundary conditions:
  - CHUNK==WIDTH: NSLICE=1, so every legal op has latency 2.
  - Difference only in bit 0: all NSLICE slices are examined.

## Test plan
All scenarios use WIDTH=32, CHUNK=8.
- Low-byte difference, unsigned: op1=100, op2=250.
  - op=011 → result=0; op=010 → 1; op=001 → 0.
  - Each has 4 slices examined and out_valid 5 cycles after accept.
- Sign handling: op1=0x8000_0000, op2=1.
  - Unsigned, op=001 → 1. Signed, op=001 → 0. Signed, op=010 → 1.
  - Each stops after 1 slice, with out_valid 2 cycles after accept.
- Equal operands: op1=op2=10.
  - eq=1, ge=1, le=1, ne=0, gt=0, lt=0.
  - Latency 5 in each case, signed and unsigned alike.
- Illegal op: operation=100 → out_valid 1 cycle after accept, result=0, illegal=1. The next legal op has illegal=0.
- Backpressure: hold out_ready=0 for 6 cycles in DONE.
  - out_valid, result and illegal stay stable and in_ready=0.
  - A new in_valid with different operands is not captured.
  - Raise out_ready → IDLE next cycle, then the queued request is accepted and answered correctly.
- Reset mid-SCAN: op1=10, op2=10, rst_n low on the 2nd SCAN cycle.
  - Next edge: state is IDLE, out_valid=0, result=0, and no result is emitted.
  - A following request (op1=5, op2=3, op=001) returns 1 with latency 5.

Source files
------------

// File: rtl/cmp_unit_seq_if.sv
// ----------------------------------------------------------------------------
// cmp_unit_seq_if
// Operand/result handshake bundle for the sequential compare unit.
//   in_valid / in_ready   : operand request handshake (requester -> unit)
//   op1, op2              : WIDTH-bit operands
//   operation             : [1:0] relation (11 eq, 01 gt, 10 lt), [2] inverts
//   is_signed             : 1 = two's-complement compare
//   out_valid / out_ready : result handshake (unit -> consumer)
//   result, illegal       : compare outcome and illegal-operation flag
// Modports: master = requester/consumer side, slave = compare unit side.
// ----------------------------------------------------------------------------
interface cmp_unit_seq_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op1;
   logic [WIDTH-1:0] op2;
   logic [2:0]       operation;
   logic             is_signed;
   logic             out_valid;
   logic             out_ready;
   logic             result;
   logic             illegal;

   modport master (
      output in_valid, op1, op2, operation, is_signed, out_ready,
      input  in_ready, out_valid, result, illegal
   );

   modport slave (
      input  in_valid, op1, op2, operation, is_signed, out_ready,
      output in_ready, out_valid, result, illegal
   );
endinterface

// File: rtl/cmp_unit_seq.sv
// ----------------------------------------------------------------------------
// cmp_unit_seq
// Sequential compare unit for the branch / set-on-compare path. Operands are
// compared MSB-first in CHUNK-bit slices, one slice per cycle, stopping at the
// first slice that differs. Only the top slice honours is_signed (its MSB is
// the sign bit); lower slices are always compared unsigned.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : cmp_unit_seq_if.slave (operand and result handshakes)
// Parameters:
//   WIDTH : operand width, multiple of CHUNK
//   CHUNK : bits compared per cycle
// ----------------------------------------------------------------------------
module cmp_unit_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   cmp_unit_seq_if.slave bus
);

   localparam int NSLICE = WIDTH / CHUNK;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] op1_r;
   logic [WIDTH-1:0] op2_r;
   logic [2:0]       op_r;
   logic             signed_r;
   logic [IDXW-1:0]  idx_r;
   logic             result_r;
   logic             illegal_r;
   logic             out_valid_r;

   logic [CHUNK-1:0] slice_a_s;
   logic [CHUNK-1:0] slice_b_s;
   logic             differ_s;
   logic             lt_s;

   // Map lt/gt/eq flags onto the requested relation; bit 2 inverts it.
   function automatic logic calc_result(input logic [2:0] op,
                                        input logic       lt,
                                        input logic       gt,
                                        input logic       eq);
      logic base;
      case (op[1:0])
         2'b11:   base = eq;
         2'b01:   base = gt;
         2'b10:   base = lt;
         default: base = 1'b0;
      endcase
      return base ^ op[2];
   endfunction

   // Select the current slice pair and decide their ordering.
   always_comb begin
      slice_a_s = op1_r[int'(idx_r) * CHUNK +: CHUNK];
      slice_b_s = op2_r[int'(idx_r) * CHUNK +: CHUNK];
      differ_s  = (slice_a_s != slice_b_s);
      // Sign only matters on the most significant slice.
      if ((idx_r == IDX_TOP) && signed_r) begin
         lt_s = ($signed(slice_a_s) < $signed(slice_b_s));
      end else begin
         lt_s = (slice_a_s < slice_b_s);
      end
   end

   assign bus.in_ready  = (state_r == ST_IDLE);
   assign bus.out_valid = out_valid_r;
   assign bus.result    = result_r;
   assign bus.illegal   = illegal_r;

   // Control FSM with operand capture and registered result outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         op1_r       <= '0;
         op2_r       <= '0;
         op_r        <= 3'b000;
         signed_r    <= 1'b0;
         idx_r       <= '0;
         result_r    <= 1'b0;
         illegal_r   <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  op1_r    <= bus.op1;
                  op2_r    <= bus.op2;
                  op_r     <= bus.operation;
                  signed_r <= bus.is_signed;
                  idx_r    <= IDX_TOP;
                  if (bus.operation[1:0] == 2'b00) begin
                     // Illegal relation: answer immediately without scanning.
                     state_r     <= ST_DONE;
                     result_r    <= 1'b0;
                     illegal_r   <= 1'b1;
                     out_valid_r <= 1'b1;
                  end else begin
                     state_r   <= ST_SCAN;
                     illegal_r <= 1'b0;
                  end
               end
            end
            ST_SCAN: begin
               if (differ_s) begin
                  // First differing slice fully decides the ordering.
                  result_r    <= calc_result(op_r, lt_s, !lt_s, 1'b0);
                  out_valid_r <= 1'b1;
                  state_r     <= ST_DONE;
               end else if (idx_r == '0) begin
                  result_r    <= calc_result(op_r, 1'b0, 1'b0, 1'b1);
                  out_valid_r <= 1'b1;
                  state_r     <= ST_DONE;
               end else begin
                  idx_r <= idx_r - IDXW'(1);
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_unit_seq.sv
// ----------------------------------------------------------------------------
// tb_cmp_unit_seq
// Directed self-checking bench for cmp_unit_seq (WIDTH=32, CHUNK=8).
// Inputs change at falling edges or just after rising edges; outputs are
// sampled at falling edges.
// ----------------------------------------------------------------------------
module tb_cmp_unit_seq;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   cmp_unit_seq_if #(.WIDTH(32)) bus ();

   cmp_unit_seq #(.WIDTH(32), .CHUNK(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a request at a falling edge; it is accepted at the next rising edge.
   task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic sgn);
      @(negedge clk);
      check({tag, "/in_ready"}, {31'd0, bus.in_ready}, 32'd1);
      bus.op1       = a;
      bus.op2       = b;
      bus.operation = op;
      bus.is_signed = sgn;
      bus.in_valid  = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   // Count edges from the accept edge until out_valid is seen, then check outputs.
   task automatic wait_result(input string tag, input logic exp_res, input logic exp_ill,
                              input int exp_lat);
      int lat;
      lat = 0;
      while (1) begin
         @(negedge clk);
         lat++;
         if (bus.out_valid === 1'b1) break;
         if (lat > 20) break;
      end
      check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "/result"}, {31'd0, bus.result}, {31'd0, exp_res});
      check({tag, "/illegal"}, {31'd0, bus.illegal}, {31'd0, exp_ill});
      check({tag, "/busy"}, {31'd0, bus.in_ready}, 32'd0);
   endtask

   // With out_ready high the unit is back in IDLE one cycle later.
   task automatic retire(input string tag);
      @(negedge clk);
      check({tag, "/ov_drop"}, {31'd0, bus.out_valid}, 32'd0);
   endtask

   task automatic txn(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic sgn, input logic exp_res,
                      input logic exp_ill, input int exp_lat);
      issue(tag, a, b, op, sgn);
      wait_result(tag, exp_res, exp_ill, exp_lat);
      retire(tag);
   endtask

   logic [2:0] eq_ops [6];
   logic       eq_exp [6];

   initial begin
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.op1       = 32'd0;
      bus.op2       = 32'd0;
      bus.operation = 3'b000;
      bus.is_signed = 1'b0;
      bus.out_ready = 1'b1;
      eq_ops = '{3'b011, 3'b110, 3'b101, 3'b111, 3'b001, 3'b010};
      eq_exp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst/out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst/result", {31'd0, bus.result}, 32'd0);
      check("rst/illegal", {31'd0, bus.illegal}, 32'd0);
      check("rst/in_ready", {31'd0, bus.in_ready}, 32'd1);
      rst_n = 1'b1;

      // Low-byte difference, unsigned: all four slices examined
      txn("lowbyte_eq", 32'd100, 32'd250, 3'b011, 1'b0, 1'b0, 1'b0, 5);
      txn("lowbyte_lt", 32'd100, 32'd250, 3'b010, 1'b0, 1'b1, 1'b0, 5);
      txn("lowbyte_gt", 32'd100, 32'd250, 3'b001, 1'b0, 1'b0, 1'b0, 5);

      // Sign handling: decided on the top slice
      txn("sign_u_gt", 32'h8000_0000, 32'd1, 3'b001, 1'b0, 1'b1, 1'b0, 2);
      txn("sign_s_gt", 32'h8000_0000, 32'd1, 3'b001, 1'b1, 1'b0, 1'b0, 2);
      txn("sign_s_lt", 32'h8000_0000, 32'd1, 3'b010, 1'b1, 1'b1, 1'b0, 2);

      // Equal operands: every relation, signed and unsigned
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 6; i++) begin
            txn($sformatf("equal_s%0d_op%0b", s, eq_ops[i]), 32'd10, 32'd10,
                eq_ops[i], s[0], eq_exp[i], 1'b0, 5);
         end
      end

      // Illegal operations, then a legal one clears the flag
      txn("illegal_100", 32'd7, 32'd7, 3'b100, 1'b0, 1'b0, 1'b1, 1);
      txn("illegal_000", 32'd1, 32'd2, 3'b000, 1'b1, 1'b0, 1'b1, 1);
      txn("after_illegal", 32'd100, 32'd250, 3'b011, 1'b0, 1'b0, 1'b0, 5);

      // Backpressure: result held, new request queued but not captured
      bus.out_ready = 1'b0;
      issue("bp", 32'd100, 32'd250, 3'b001, 1'b0);
      wait_result("bp", 1'b0, 1'b0, 5);
      bus.op1       = 32'd7;
      bus.op2       = 32'd9;
      bus.operation = 3'b010;
      bus.is_signed = 1'b0;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("bp_hold%0d/out_valid", i), {31'd0, bus.out_valid}, 32'd1);
         check($sformatf("bp_hold%0d/result", i), {31'd0, bus.result}, 32'd0);
         check($sformatf("bp_hold%0d/illegal", i), {31'd0, bus.illegal}, 32'd0);
         check($sformatf("bp_hold%0d/in_ready", i), {31'd0, bus.in_ready}, 32'd0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("bp_release/out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("bp_release/in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      wait_result("bp_queued", 1'b1, 1'b0, 5);
      retire("bp_queued");

      // Reset in the second SCAN cycle aborts the operation
      issue("rst_scan", 32'd10, 32'd10, 3'b011, 1'b0);
      @(negedge clk);
      check("rst_scan/scan1_ov", {31'd0, bus.out_valid}, 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_scan/out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_scan/result", {31'd0, bus.result}, 32'd0);
      check("rst_scan/in_ready", {31'd0, bus.in_ready}, 32'd1);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("rst_scan_quiet%0d", i), {31'd0, bus.out_valid}, 32'd0);
      end
      txn("after_rst", 32'd5, 32'd3, 3'b001, 1'b0, 1'b1, 1'b0, 5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
